// File: rtl/rx_cal_tx_pkg.sv
// Shared MBTRAIN definitions: step state encodings and sideband message codes.
package rx_cal_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE            = 3'd0,
        ST_SEND_START_REQ  = 3'd1,
        ST_WAIT_START_RESP = 3'd2,
        ST_CAL_RUN         = 3'd3,
        ST_SEND_END_REQ    = 3'd4,
        ST_WAIT_END_RESP   = 3'd5,
        ST_TEST_FINISHED   = 3'd6,
        ST_TIMEOUT         = 3'd7
    } mbtrain_state_e;

    localparam logic [3:0] SB_NONE       = 4'b0000;
    localparam logic [3:0] SB_START_REQ  = 4'b0001;
    localparam logic [3:0] SB_START_RESP = 4'b0010;
    localparam logic [3:0] SB_END_REQ    = 4'b0011;
    localparam logic [3:0] SB_END_RESP   = 4'b0100;

    // States in which the timeout counter runs and i_en low aborts the step.
    function automatic logic is_active_state(input mbtrain_state_e s);
        return (s != ST_IDLE) && (s != ST_TEST_FINISHED) && (s != ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/rx_cal_tx_sb_valid_handshake.sv
// Sideband transmit valid handshake shared by the initiator and responder
// halves: pending flag, valid register and falling-edge detect of the valid.
module sb_valid_handshake (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic set,
    input  logic busy_negedge,
    input  logic valid_rx,
    output logic valid_tx,
    output logic valid_fall
);

    logic pending;
    logic valid_reg;

    // Pending flag: armed on entry to a send state, dropped once the sideband finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (clr || busy_negedge) begin
            pending <= 1'b0;
        end else if (set) begin
            pending <= 1'b1;
        end
    end

    // Valid: raised while the responder is not driving the sideband; busy pulse wins over a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_tx <= 1'b0;
        end else if (clr || busy_negedge) begin
            valid_tx <= 1'b0;
        end else if ((pending || set) && !valid_rx) begin
            valid_tx <= 1'b1;
        end
    end

    // Delayed copy of the valid for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= valid_tx;
        end
    end

    assign valid_fall = valid_reg & ~valid_tx;

endmodule

// File: rtl/rx_cal_tx.sv
// MBTRAIN RX-clock-calibration initiator: start request/response, local PHY
// calibration, end request/response, with a timeout over the whole exchange.
//
// state              | meaning
// IDLE               | step not enabled, everything cleared
// SEND_START_REQ     | start request offered on the sideband
// WAIT_START_RESP    | waiting for partner start response (0010)
// CAL_RUN            | PHY RX calibration requested, waiting for done
// SEND_END_REQ       | end request offered on the sideband
// WAIT_END_RESP      | waiting for partner end response (0100)
// TEST_FINISHED      | step acknowledged to LTSM until i_en drops
// TIMEOUT            | exchange took too long, held until i_en drops
module rx_cal_tx
    import rx_cal_tx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 800000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [3:0] i_decoded_sideband_message,
    input  logic       i_busy_negedge_detected,
    input  logic       i_valid_rx,
    input  logic       i_cal_done,
    output logic [3:0] o_sideband_message,
    output logic       o_valid_tx,
    output logic       o_cal_en,
    output logic       o_test_ack,
    output logic       o_timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    mbtrain_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0] msg_d;
    logic cal_en_d, ack_d, timeout_d;
    logic hs_set, hs_clr, valid_fall;

    sb_valid_handshake u_hs (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (hs_clr),
        .set          (hs_set),
        .busy_negedge (i_busy_negedge_detected),
        .valid_rx     (i_valid_rx),
        .valid_tx     (o_valid_tx),
        .valid_fall   (valid_fall)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: normal sequencing, then timeout, then abort on i_en low (highest priority).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:            if (i_en) state_d = ST_SEND_START_REQ;
            ST_SEND_START_REQ:  if (valid_fall) state_d = ST_WAIT_START_RESP;
            ST_WAIT_START_RESP: if (i_decoded_sideband_message == SB_START_RESP) state_d = ST_CAL_RUN;
            ST_CAL_RUN:         if (i_cal_done) state_d = ST_SEND_END_REQ;
            ST_SEND_END_REQ:    if (valid_fall) state_d = ST_WAIT_END_RESP;
            ST_WAIT_END_RESP:   if (i_decoded_sideband_message == SB_END_RESP) state_d = ST_TEST_FINISHED;
            ST_TEST_FINISHED:   if (!i_en) state_d = ST_IDLE;
            ST_TIMEOUT:         if (!i_en) state_d = ST_IDLE;
            default:            state_d = ST_IDLE;
        endcase
        if (is_active_state(state_q)) begin
            if (!i_en) begin
                state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    // Output decode from the upcoming state; message only changes on a transition.
    always_comb begin
        msg_d = o_sideband_message;
        if (state_d != state_q) begin
            case (state_d)
                ST_SEND_START_REQ: msg_d = SB_START_REQ;
                ST_SEND_END_REQ:   msg_d = SB_END_REQ;
                ST_IDLE, ST_TEST_FINISHED, ST_TIMEOUT: msg_d = SB_NONE;
                default:           msg_d = o_sideband_message;
            endcase
        end
        cal_en_d  = (state_d == ST_CAL_RUN);
        ack_d     = (state_d == ST_TEST_FINISHED);
        timeout_d = (state_d == ST_TIMEOUT);
        hs_set    = (state_d != state_q) &&
                    ((state_d == ST_SEND_START_REQ) || (state_d == ST_SEND_END_REQ));
        hs_clr    = (state_d == ST_IDLE);
    end

    // Registered outputs, updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sideband_message <= SB_NONE;
            o_cal_en           <= 1'b0;
            o_test_ack         <= 1'b0;
            o_timeout          <= 1'b0;
        end else begin
            o_sideband_message <= msg_d;
            o_cal_en           <= cal_en_d;
            o_test_ack         <= ack_d;
            o_timeout          <= timeout_d;
        end
    end

    // Timeout counter spans the whole exchange; it is never restarted between phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!is_active_state(state_q)) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_rx_cal_tx.sv
// Scoreboard bench for rx_cal_tx: stimulus pushes expected output snapshots
// stamped with the cycle they should appear; a monitor compares every change.
module tb_rx_cal_tx;

    typedef struct {
        int         cyc;
        logic [7:0] outs;   // {msg[3:0], valid_tx, cal_en, test_ack, timeout}
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_en = 1'b0;
    logic [3:0] i_decoded_sideband_message = 4'b0000;
    logic       i_busy_negedge_detected = 1'b0;
    logic       i_valid_rx = 1'b0;
    logic       i_cal_done = 1'b0;
    logic [3:0] o_sideband_message;
    logic       o_valid_tx;
    logic       o_cal_en;
    logic       o_test_ack;
    logic       o_timeout;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    exp_t e;
    logic [7:0] cur;
    logic [7:0] last = 8'h00;

    rx_cal_tx #(.TIMEOUT_CYCLES(50), .CNT_W(6)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .i_en                       (i_en),
        .i_decoded_sideband_message (i_decoded_sideband_message),
        .i_busy_negedge_detected    (i_busy_negedge_detected),
        .i_valid_rx                 (i_valid_rx),
        .i_cal_done                 (i_cal_done),
        .o_sideband_message         (o_sideband_message),
        .o_valid_tx                 (o_valid_tx),
        .o_cal_en                   (o_cal_en),
        .o_test_ack                 (o_test_ack),
        .o_timeout                  (o_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] outs_now();
        return {o_sideband_message, o_valid_tx, o_cal_en, o_test_ack, o_timeout};
    endfunction

    task automatic push(input int c, input logic [3:0] m, input logic v,
                        input logic ce, input logic ak, input logic to);
        exp_t x;
        x.cyc  = c;
        x.outs = {m, v, ce, ak, to};
        exp_q.push_back(x);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b want %b (cyc %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every change of the output bundle must match the next expected snapshot and cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            cur = outs_now();
            if (cur !== last) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_change: got %b at cyc %0d, nothing expected", cur, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.outs !== cur || e.cyc != cyc) begin
                        n_err++;
                        $display("FAIL scoreboard: got %b at cyc %0d, want %b at cyc %0d",
                                 cur, cyc, e.outs, e.cyc);
                    end
                end
                last = cur;
            end
        end
    end

    task automatic busy_pulse(input logic [3:0] m);
        i_busy_negedge_detected = 1'b1;
        push(cyc + 1, m, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        i_busy_negedge_detected = 1'b0;
    endtask

    // Full successful exchange starting from IDLE with i_en low and i_valid_rx low.
    task automatic run_happy(input int cal_len);
        int p;
        @(negedge clk);
        i_en = 1'b1;
        push(cyc + 1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        busy_pulse(4'b0001);
        @(negedge clk);
        i_decoded_sideband_message = 4'b0010;
        push(cyc + 1, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
        p = cyc + 1;
        @(negedge clk);
        i_decoded_sideband_message = 4'b0000;
        while (cyc < p + cal_len - 1) @(negedge clk);
        i_cal_done = 1'b1;
        push(cyc + 1, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        i_cal_done = 1'b0;
        repeat (2) @(negedge clk);
        busy_pulse(4'b0011);
        @(negedge clk);
        i_decoded_sideband_message = 4'b0100;
        push(cyc + 1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        i_decoded_sideband_message = 4'b0000;
        repeat (2) @(negedge clk);
        i_en = 1'b0;
        push(cyc + 1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int s;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk("reset_outputs", outs_now(), 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs", outs_now(), 8'h00);
        last   = outs_now();
        mon_en = 1'b1;

        // Happy path, calibration running 10 cycles.
        run_happy(10);

        // Deferral by the responder around start-request entry, then wrong codes, then abort in CAL_RUN.
        @(negedge clk);
        i_valid_rx = 1'b1;
        @(negedge clk);
        i_en = 1'b1;
        push(cyc + 1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        i_valid_rx = 1'b0;
        push(cyc + 1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        busy_pulse(4'b0001);
        @(negedge clk);
        i_decoded_sideband_message = 4'b0100;
        @(negedge clk);
        i_decoded_sideband_message = 4'b0011;
        @(negedge clk);
        i_decoded_sideband_message = 4'b0000;
        repeat (2) @(negedge clk);
        i_decoded_sideband_message = 4'b0010;
        push(cyc + 1, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        i_decoded_sideband_message = 4'b0000;
        repeat (3) @(negedge clk);
        i_en = 1'b0;
        push(cyc + 1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Timeout: start request sent, partner never answers.
        i_en = 1'b1;
        s = cyc;
        push(s + 1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        busy_pulse(4'b0001);
        push(s + 51, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        while (cyc < s + 55) @(negedge clk);
        i_en = 1'b0;
        push(cyc + 1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Async reset while the start request is valid, then a clean restart.
        i_en = 1'b1;
        push(cyc + 1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        push(cyc, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1 chk("async_reset_outputs", outs_now(), 8'h00);
        i_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_happy(3);

        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_changes: %0d expected snapshots never seen, next want %b at cyc %0d",
                     exp_q.size(), exp_q[0].outs, exp_q[0].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish by time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
